// File: rtl/servant_timer_mc.sv
// Prescaled multi-channel compare timer on a Wishbone slave port; 1-cycle registered read/ack latency.
// No backpressure: one request accepted per 2 cycles, ack forced low the cycle after each ack.
module servant_timer_mc #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_irq
);

    typedef logic [WIDTH-1:0] word_t;

    word_t               mtime_q, mtime_d, mtime_inc;
    logic [7:0]          pcnt_q, pcnt_d;
    logic [7:0]          presc_q, presc_d;
    logic                enable_q, enable_d;
    logic [CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [CHANNELS-1:0] pend_q, pend_d, match;
    word_t               cmp_q [CHANNELS];
    word_t               cmp_d [CHANNELS];
    word_t               period_q [CHANNELS];
    word_t               period_d [CHANNELS];
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d, rdata;
    logic                irq_q, irq_d;
    logic                req, wr, tick, wr_mtime, wr_ctrl;
    logic                unused_dat;

    assign unused_dat = ^i_wb_dat;

    always_comb begin
        req       = i_wb_cyc & ~ack_q;
        wr        = req & i_wb_we;
        wr_mtime  = wr && (i_wb_adr == 4'd0);
        wr_ctrl   = wr && (i_wb_adr == 4'd1);
        tick      = enable_q && (pcnt_q == presc_q);
        mtime_inc = mtime_q + word_t'(1);

        pcnt_d   = pcnt_q + 8'd1;
        if (wr_ctrl || !enable_q || tick)
            pcnt_d = 8'd0;

        enable_d = enable_q;
        presc_d  = presc_q;
        if (wr_ctrl) begin
            enable_d = i_wb_dat[0];
            presc_d  = i_wb_dat[15:8];
        end

        // A bus write to MTIME swallows the tick of the same cycle, match included.
        mtime_d = mtime_q;
        if (wr_mtime)
            mtime_d = i_wb_dat[WIDTH-1:0];
        else if (tick)
            mtime_d = mtime_inc;

        irq_en_d = irq_en_q;
        if (wr && (i_wb_adr == 4'd2))
            irq_en_d = i_wb_dat[CHANNELS-1:0];

        pend_d = pend_q;
        if (wr && (i_wb_adr == 4'd3))
            pend_d = pend_q & ~i_wb_dat[CHANNELS-1:0];

        for (int n = 0; n < CHANNELS; n++) begin
            match[n]    = tick && !wr_mtime && (mtime_inc == cmp_q[n]);
            cmp_d[n]    = cmp_q[n];
            period_d[n] = period_q[n];
            if (match[n])
                pend_d[n] = 1'b1;
            if (match[n] && (period_q[n] != '0))
                cmp_d[n] = cmp_q[n] + period_q[n];
            if (wr && (i_wb_adr == 4'(4 + 2*n)))
                cmp_d[n] = i_wb_dat[WIDTH-1:0];
            if (wr && (i_wb_adr == 4'(5 + 2*n)))
                period_d[n] = i_wb_dat[WIDTH-1:0];
        end

        rdata = 32'd0;
        case (i_wb_adr)
            4'd0:    rdata = 32'(mtime_q);
            4'd1:    rdata = {16'd0, presc_q, 7'd0, enable_q};
            4'd2:    rdata = 32'(irq_en_q);
            4'd3:    rdata = 32'(pend_q);
            default: rdata = 32'd0;
        endcase
        for (int n = 0; n < CHANNELS; n++) begin
            if (i_wb_adr == 4'(4 + 2*n))
                rdata = 32'(cmp_q[n]);
            if (i_wb_adr == 4'(5 + 2*n))
                rdata = 32'(period_q[n]);
        end

        ack_d = req;
        dat_d = req ? rdata : 32'd0;
        irq_d = |(pend_q & irq_en_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_q  <= '0;
            pcnt_q   <= '0;
            presc_q  <= '0;
            enable_q <= 1'b0;
            irq_en_q <= '0;
            pend_q   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                cmp_q[n]    <= '0;
                period_q[n] <= '0;
            end
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            pcnt_q   <= pcnt_d;
            presc_q  <= presc_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            for (int n = 0; n < CHANNELS; n++) begin
                cmp_q[n]    <= cmp_d[n];
                period_q[n] <= period_d[n];
            end
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    assign o_wb_dat = dat_q;
    assign o_wb_ack = ack_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_timer_mc.sv
// Directed bench for servant_timer_mc (WIDTH=8, CHANNELS=2); comments count edges from the CTRL-enable edge C.
module tb_servant_timer_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic        we;
    logic        cyc;
    logic [31:0] rdat;
    logic        ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servant_timer_mc #(.WIDTH(8), .CHANNELS(2)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wb_adr (adr),
        .i_wb_dat (wdat),
        .i_wb_we  (we),
        .i_wb_cyc (cyc),
        .o_wb_dat (rdat),
        .o_wb_ack (ack),
        .o_irq    (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after an edge; commits at the next edge and returns one edge later.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        adr = a; wdat = d; we = 1'b1; cyc = 1'b1;
        step(1);
        cyc = 1'b0; we = 1'b0;
        step(1);
    endtask

    // Returns register state as it was when the task was entered.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        check({tag, "_ack_pre"}, {31'd0, ack}, 32'd0);
        adr = a; we = 1'b0; cyc = 1'b1;
        step(1);
        cyc = 1'b0;
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        check(tag, rdat, exp);
        step(1);
    endtask

    initial begin
        rst = 1'b1; adr = 4'd0; wdat = 32'd0; we = 1'b0; cyc = 1'b0;
        step(3);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        rst = 1'b0;
        step(1);

        for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, "rst_read");

        // Held cyc: ack alternates 1,0,1,0
        adr = 4'd0; we = 1'b0; cyc = 1'b1;
        check("pat_0", {31'd0, ack}, 32'd0);
        step(1); check("pat_1", {31'd0, ack}, 32'd1);
        step(1); check("pat_2", {31'd0, ack}, 32'd0);
        step(1); check("pat_3", {31'd0, ack}, 32'd1);
        step(1); check("pat_4", {31'd0, ack}, 32'd0);
        cyc = 1'b0;
        step(1);

        // Prescale P=3: one tick per 4 cycles, CMP0=10
        wr(4'd4, 32'd10);
        wr(4'd2, 32'd1);
        wr(4'd1, 32'h0000_0301);                 // C; now after C+1
        step(6);                                 // after C+7
        rd(4'd0, 32'd1, "p3_mtime_a");
        rd(4'd0, 32'd2, "p3_mtime_b");           // now after C+11
        step(28);
        check("p3_irq_early", {31'd0, irq}, 32'd0);
        step(1);                                 // pend set at C+40
        check("p3_irq_lag", {31'd0, irq}, 32'd0);
        step(1);
        check("p3_irq_rise", {31'd0, irq}, 32'd1);
        rd(4'd3, 32'd1, "p3_pend");
        wr(4'd3, 32'd1);
        check("p3_irq_fall", {31'd0, irq}, 32'd0);
        step(40);                                // after C+85
        check("p3_no_retrig", {31'd0, irq}, 32'd0);
        rd(4'd0, 32'd21, "p3_mtime_c");
        rd(4'd3, 32'd0, "p3_pend_clr");
        wr(4'd1, 32'd0);
        wr(4'd3, 32'd3);

        // Counter wrap FE -> FF -> 00 matches CMP1=0
        wr(4'd6, 32'd0);
        wr(4'd0, 32'h0000_00FE);
        wr(4'd3, 32'd3);
        wr(4'd1, 32'd1);
        wr(4'd1, 32'd0);
        rd(4'd0, 32'd0, "wrap_mtime");
        rd(4'd3, 32'd2, "wrap_pend1");
        wr(4'd3, 32'd3);

        // Writing MTIME equal to CMP1 does not match
        wr(4'd0, 32'h0000_0080);
        wr(4'd6, 32'd5);
        wr(4'd1, 32'd1);                         // C
        wr(4'd0, 32'd5);                         // C+2
        wr(4'd1, 32'd0);                         // C+4
        rd(4'd0, 32'd7, "wr_mtime_count");
        rd(4'd3, 32'd0, "wr_mtime_nopend");

        // MTIME write lands on a tick edge
        wr(4'd1, 32'h0000_0301);                 // C
        step(2);
        wr(4'd0, 32'h0000_0040);                 // C+4
        rd(4'd0, 32'h0000_0040, "mtime_vs_tick");
        wr(4'd1, 32'd0);

        // Periodic: CMP0=5, PERIOD0=7, matches at 5, 12, 19, 26
        wr(4'd3, 32'd3);
        wr(4'd6, 32'h0000_00FF);
        wr(4'd4, 32'd5);
        wr(4'd5, 32'd7);
        wr(4'd0, 32'd0);
        wr(4'd1, 32'd1);                         // C
        step(4);
        check("per_irq_lag", {31'd0, irq}, 32'd0);
        step(1);
        check("per_m5", {31'd0, irq}, 32'd1);
        rd(4'd4, 32'd12, "per_cmp_reload");
        wr(4'd3, 32'd1);                         // C+9
        check("per_clr1", {31'd0, irq}, 32'd0);
        step(2);
        check("per_pre12", {31'd0, irq}, 32'd0);
        step(1);
        check("per_m12", {31'd0, irq}, 32'd1);
        wr(4'd3, 32'd1);                         // C+14
        check("per_clr2", {31'd0, irq}, 32'd0);
        step(5);
        check("per_m19", {31'd0, irq}, 32'd1);
        step(5);
        wr(4'd3, 32'd1);                         // C+26, same edge as match
        wr(4'd1, 32'd0);
        rd(4'd3, 32'd1, "clr_vs_set");
        rd(4'd4, 32'd33, "per_cmp_33");

        // Compare reload wraps: 0xFC + 8 -> 0x04
        wr(4'd4, 32'h0000_00FC);
        wr(4'd5, 32'd8);
        wr(4'd0, 32'h0000_00FB);
        wr(4'd3, 32'd3);
        wr(4'd1, 32'd1);
        wr(4'd1, 32'd0);
        rd(4'd4, 32'h0000_0004, "cmp_wrap");
        rd(4'd3, 32'd1, "cmp_wrap_pend");

        // Field masking and absent/unmapped addresses
        wr(4'd0, 32'hFFFF_FF12);
        rd(4'd0, 32'h0000_0012, "mtime_trunc");
        wr(4'd1, 32'hFFFF_FFFE);
        rd(4'd1, 32'h0000_FF00, "ctrl_fields");
        wr(4'd1, 32'd0);
        wr(4'd2, 32'hFFFF_FFFF);
        rd(4'd2, 32'd3, "irq_en_mask");
        wr(4'd2, 32'd1);
        wr(4'd8, 32'h0000_0055);
        rd(4'd8, 32'd0, "absent_cmp");
        rd(4'd15, 32'd0, "unmapped");

        // Reset during an active transaction with irq high
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        wr(4'd1, 32'd1);
        adr = 4'd3; we = 1'b0; cyc = 1'b1;
        step(1);
        check("rst_mid_ack_pre", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        step(1);
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        cyc = 1'b0; rst = 1'b0;
        step(1);
        for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, "post_rst_read");
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        step(5);
        rd(4'd0, 32'd0, "post_rst_mtime_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
